// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that shares one cache controller among NREQ requesters,
// issues the captured command, waits for completion (with timeout) and keeps hit/miss statistics.
module cache_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic                 c_bgn,
  output logic                 c_read,
  output logic                 c_write,
  output logic [AW-1:0]        c_addr,
  output logic [DW-1:0]        c_wdata,
  input  logic                 c_done,
  input  logic                 c_hit,
  input  logic [DW-1:0]        c_rdata,
  input  logic                 clr_stats,
  output logic                 busy,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [15:0]     hit_q, hit_d;
  logic [15:0]     miss_q, miss_d;
  logic            hit_inc_s, miss_inc_s;
  logic [IW-1:0]   pick_s;
  logic [2*NREQ-1:0] rot_s;
  logic [NREQ-1:0] idx_oh_s;
  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    s = (s >= NREQ) ? s - NREQ : s;
    return s[IW-1:0];
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*AW +: AW];
    assign wdata_a[g] = req_wdata[g*DW +: DW];
  end

  // Rotating by ptr puts the highest-priority requester at bit 0.
  assign rot_s = {req, req} >> ptr_q;

  // Lowest rotated position with a request wins.
  always_comb begin
    pick_s = {IW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      pick_s = rot_s[k] ? wrap_add(ptr_q, k) : pick_s;
    end
  end

  // Transaction FSM next-state and datapath capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tmo_d      = tmo_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    hit_inc_s  = 1'b0;
    miss_inc_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_ISSUE;
          idx_d   = pick_s;
          wr_d    = req_wr[pick_s];
          addr_d  = addr_a[pick_s];
          wdata_d = wdata_a[pick_s];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = {TW{1'b0}};
      end
      S_WAIT: begin
        // A completion on the final timeout cycle still counts as success.
        if (c_done) begin
          state_d    = S_RESP;
          rdata_d    = c_rdata;
          err_d      = 1'b0;
          hit_inc_s  = c_hit;
          miss_inc_s = ~c_hit;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = wrap_add(idx_q, 1);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign hit_d  = clr_stats ? 16'h0000 :
                  (hit_inc_s && (hit_q != 16'hFFFF)) ? hit_q + 16'd1 : hit_q;
  assign miss_d = clr_stats ? 16'h0000 :
                  (miss_inc_s && (miss_q != 16'hFFFF)) ? miss_q + 16'd1 : miss_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= {IW{1'b0}};
      ptr_q   <= {IW{1'b0}};
      wr_q    <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DW{1'b0}};
      tmo_q   <= {TW{1'b0}};
      rdata_q <= {DW{1'b0}};
      err_q   <= 1'b0;
      hit_q   <= 16'h0000;
      miss_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign idx_oh_s  = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
  assign gnt       = (state_q == S_ISSUE) ? idx_oh_s : {NREQ{1'b0}};
  assign ack       = (state_q == S_RESP)  ? idx_oh_s : {NREQ{1'b0}};
  assign c_bgn     = (state_q == S_ISSUE);
  assign c_read    = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !wr_q;
  assign c_write   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && wr_q;
  assign c_addr    = addr_q;
  assign c_wdata   = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;

endmodule
